// File: rtl/bsg_credit_to_ready_flow_converter_pkg.sv
// Shared helpers for the credit-to-ready flow converter.
package bsg_credit_to_ready_flow_converter_pkg;

  // clog2 that never returns 0, so a depth of 1 still gets a 1-bit pointer
  function automatic int safe_clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bsg_credit_rx_wrap_ptr.sv
// Pointer that counts 0..els_p-1 and wraps to zero, for any depth.
module bsg_credit_rx_wrap_ptr
  import bsg_credit_to_ready_flow_converter_pkg::*;
#(
  parameter int els_p = 8,
  localparam int ptr_width_lp = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    incr_i,
  output logic [ptr_width_lp-1:0] ptr_o
);

  localparam logic [ptr_width_lp-1:0] last_lp = ptr_width_lp'(els_p - 1);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;

  // explicit wrap at els_p-1 keeps non-power-of-2 depths correct
  always_comb begin
    ptr_d = ptr_q;
    if (incr_i) begin
      if (ptr_q == last_lp) begin
        ptr_d = ptr_width_lp'(0);
      end else begin
        ptr_d = ptr_q + ptr_width_lp'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= ptr_width_lp'(0);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_credit_to_ready_flow_converter.sv
// Receive side of a credit link: buffers incoming beats, presents them as
// valid/yumi and returns one credit per dequeue.
module bsg_credit_to_ready_flow_converter
  import bsg_credit_to_ready_flow_converter_pkg::*;
#(
  parameter int width_p = 32,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               credit_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               overflow_o
);

  localparam int ptr_width_lp   = safe_clog2(els_p);
  localparam int count_width_lp = safe_clog2(els_p + 1);
  localparam logic [count_width_lp-1:0] els_lp = count_width_lp'(els_p);

  logic [width_p-1:0]        mem_q [els_p];
  logic [ptr_width_lp-1:0]   rd_ptr, wr_ptr;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      credit_q, credit_d;
  logic                      overflow_q, overflow_d;
  logic                      enq, deq;

  bsg_credit_rx_wrap_ptr #(.els_p(els_p)) rd_ptr_inst (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .incr_i  (deq),
    .ptr_o   (rd_ptr)
  );

  bsg_credit_rx_wrap_ptr #(.els_p(els_p)) wr_ptr_inst (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .incr_i  (enq),
    .ptr_o   (wr_ptr)
  );

  assign v_o        = (count_q != count_width_lp'(0));
  assign data_o     = mem_q[rd_ptr];
  assign credit_o   = credit_q;
  assign overflow_o = overflow_q;

  // a full buffer still accepts a beat when the head leaves in the same cycle
  always_comb begin
    deq        = yumi_i & v_o;
    enq        = v_i & ((count_q < els_lp) | deq);
    count_d    = count_q + count_width_lp'(enq) - count_width_lp'(deq);
    credit_d   = deq;
    overflow_d = overflow_q | (v_i & ~enq);
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= count_width_lp'(0);
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_bsg_credit_to_ready_flow_converter.sv
// Directed bench: a depth-8 and a depth-5 instance checked every cycle against
// a list-based receiver model plus a credit-holding sender model.
module tb_bsg_credit_to_ready_flow_converter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_in   [2];
  logic [31:0] d_in   [2];
  logic        yumi   [2];
  logic        cred_w [2];
  logic        v_w    [2];
  logic [31:0] d_w    [2];
  logic        ovf_w  [2];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state, per instance: ordered list of held beats
  int          mels   [2] = '{8, 5};
  logic [31:0] mlist  [2][8];
  int          msize  [2];
  logic        mcred  [2];
  logic        movf   [2];
  int          scred  [2];
  logic        sviol  [2];
  logic        cseen  [2];
  int          ctot   [2];
  logic        started = 1'b0;

  always #5 clk = ~clk;

  bsg_credit_to_ready_flow_converter #(.width_p(32), .els_p(8)) dut8 (
    .clk_i(clk), .reset_i(reset), .v_i(v_in[0]), .data_i(d_in[0]),
    .credit_o(cred_w[0]), .v_o(v_w[0]), .data_o(d_w[0]),
    .yumi_i(yumi[0]), .overflow_o(ovf_w[0])
  );

  bsg_credit_to_ready_flow_converter #(.width_p(32), .els_p(5)) dut5 (
    .clk_i(clk), .reset_i(reset), .v_i(v_in[1]), .data_i(d_in[1]),
    .credit_o(cred_w[1]), .v_o(v_w[1]), .data_o(d_w[1]),
    .yumi_i(yumi[1]), .overflow_o(ovf_w[1])
  );

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] t=%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  // model advances on every clock edge from the inputs driven during the cycle
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        msize[k] = 0; mcred[k] = 1'b0; movf[k] = 1'b0;
        scred[k] = mels[k]; sviol[k] = 1'b0;
      end else begin
        logic d;
        scred[k] = scred[k] + (cseen[k] ? 1 : 0);
        d = yumi[k] && (msize[k] > 0);
        if (v_in[k]) begin
          if (scred[k] == 0) sviol[k] = 1'b1;
          else scred[k] = scred[k] - 1;
        end
        if (d) begin
          for (int j = 0; j < 7; j++) mlist[k][j] = mlist[k][j+1];
          msize[k] = msize[k] - 1;
        end
        if (v_in[k]) begin
          if (msize[k] < mels[k]) begin
            mlist[k][msize[k]] = d_in[k];
            msize[k] = msize[k] + 1;
          end else begin
            movf[k] = 1'b1;
          end
        end
        mcred[k] = d;
      end
    end
  end

  // compare DUT against model mid-cycle
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check("v_o", k, 32'(v_w[k]), 32'(msize[k] != 0));
        if (msize[k] != 0) check("data_o", k, d_w[k], mlist[k][0]);
        check("credit_o", k, 32'(cred_w[k]), 32'(mcred[k]));
        check("overflow_o", k, 32'(ovf_w[k]), 32'(movf[k]));
        if (!sviol[k])
          check("credit_invariant", k, 32'(scred[k] + msize[k] + (cred_w[k] ? 1 : 0)),
                32'(mels[k]));
        if (cred_w[k]) ctot[k]++;
      end
    end
    for (int k = 0; k < 2; k++) cseen[k] = cred_w[k];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill8(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      v_in[0] = 1'b1; d_in[0] = base + 32'(i);
      step();
    end
    v_in[0] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      v_in[k] = 1'b0; d_in[k] = 32'h0; yumi[k] = 1'b0; cseen[k] = 1'b0; ctot[k] = 0;
    end
    step(); step();
    started = 1'b1;
    check("reset_v_o", 0, 32'(v_w[0]), 32'h0);
    check("reset_credit_o", 0, 32'(cred_w[0]), 32'h0);
    reset = 1'b0;
    step();

    // single beat, one-cycle latency, credit one cycle after yumi
    v_in[0] = 1'b1; d_in[0] = 32'hA5A5A5A5;
    step();
    v_in[0] = 1'b0;
    check("t1_v_o", 0, 32'(v_w[0]), 32'h1);
    check("t1_data_o", 0, d_w[0], 32'hA5A5A5A5);
    yumi[0] = 1'b1;
    step();
    yumi[0] = 1'b0;
    check("t1_credit_o", 0, 32'(cred_w[0]), 32'h1);
    check("t1_v_o_after", 0, 32'(v_w[0]), 32'h0);
    step();
    check("t1_credit_drop", 0, 32'(cred_w[0]), 32'h0);

    // yumi on empty is illegal and must be ignored
    $display("note: driving illegal yumi_i while empty");
    yumi[0] = 1'b1;
    step();
    yumi[0] = 1'b0;
    check("empty_yumi_credit", 0, 32'(cred_w[0]), 32'h0);
    step();

    // eight beats with no yumi, then drain in order
    fill8(32'd0);
    check("t2_full_v_o", 0, 32'(v_w[0]), 32'h1);
    check("t2_no_credit", 0, 32'(cred_w[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("t2_order", 0, d_w[0], 32'(i));
      yumi[0] = 1'b1;
      step();
      check("t2_credit", 0, 32'(cred_w[0]), 32'h1);
    end
    yumi[0] = 1'b0;
    step();
    check("t2_empty", 0, 32'(v_w[0]), 32'h0);

    // full with simultaneous enqueue and dequeue
    fill8(32'd10);
    v_in[0] = 1'b1; d_in[0] = 32'd99; yumi[0] = 1'b1;
    step();
    v_in[0] = 1'b0;
    check("t3_overflow", 0, 32'(ovf_w[0]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("t3_order", 0, d_w[0], (i == 7) ? 32'd99 : 32'(11 + i));
      step();
    end
    yumi[0] = 1'b0;
    step();

    // full with no dequeue: beat dropped, sticky overflow
    fill8(32'd20);
    v_in[0] = 1'b1; d_in[0] = 32'hDEAD;
    step();
    v_in[0] = 1'b0;
    check("t4_overflow", 0, 32'(ovf_w[0]), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("t4_order", 0, d_w[0], 32'(20 + i));
      yumi[0] = 1'b1;
      step();
    end
    yumi[0] = 1'b0;
    step();
    check("t4_drained", 0, 32'(v_w[0]), 32'h0);
    check("t4_sticky", 0, 32'(ovf_w[0]), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t4_reset_clears", 0, 32'(ovf_w[0]), 32'h0);
    step();

    // depth 5: 23 beats under random yumi, order across wrap
    begin
      int sent = 0;
      int cyc = 0;
      ctot[1] = 0;
      while ((sent < 23 || msize[1] != 0) && cyc < 500) begin
        v_in[1] = (sent < 23) && (scred[1] > 0);
        d_in[1] = 32'(100 + sent);
        yumi[1] = (msize[1] > 0) && ($urandom_range(1, 0) == 1);
        if (v_in[1]) sent++;
        step();
        cyc++;
      end
      v_in[1] = 1'b0; yumi[1] = 1'b0;
      check("t5_timeout", 1, 32'(cyc < 500), 32'h1);
      step(); step();
      check("t5_credit_total", 1, 32'(ctot[1]), 32'd23);
    end

    // reset with three beats queued and a dequeue in the same cycle
    for (int i = 0; i < 3; i++) begin
      v_in[0] = 1'b1; d_in[0] = 32'(40 + i);
      step();
    end
    v_in[0] = 1'b0;
    yumi[0] = 1'b1; reset = 1'b1;
    step();
    yumi[0] = 1'b0; reset = 1'b0;
    check("t6_v_o", 0, 32'(v_w[0]), 32'h0);
    check("t6_credit_o", 0, 32'(cred_w[0]), 32'h0);
    check("t6_overflow", 0, 32'(ovf_w[0]), 32'h0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
